// File: rtl/prirv32_pkg.sv
// Shared types for the priRV32 fetch slice.
// FAULT exists only when PRIRV32_IFETCH_MISALIGN_EN is defined.
package prirv32_pkg;

  typedef logic [31:0] xlen_t;
  typedef logic [31:0] inst_t;

  localparam xlen_t PRIRV32_RESET_PC = 32'h0000_0000;

`ifdef PRIRV32_IFETCH_MISALIGN_EN
  typedef enum logic {
    FETCH,
    FAULT
  } fetch_state_e;
`else
  typedef enum logic {
    FETCH
  } fetch_state_e;
`endif

  typedef struct packed {
    xlen_t pc;
    inst_t data;
  } fetch_entry_t;

endpackage

// File: rtl/rv32_ifetch_if.sv
// Instruction memory request/response channel.
// master = fetch stage, slave = memory.
interface rv32_ifetch_if;
  import prirv32_pkg::*;

  logic  imem_req_valid;
  logic  imem_req_ready;
  xlen_t imem_req_addr;
  logic  imem_rsp_valid;
  inst_t imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );

endinterface

// File: rtl/rv32_ifetch_fifo.sv
// Prefetch FIFO of {pc, data} entries.
// Flush empties the queue and wins over push and pop.
module rv32_ifetch_fifo
  import prirv32_pkg::*;
#(
  parameter int           DEPTH     = 2,
  parameter fetch_entry_t RST_ENTRY = '0,
  localparam int          AW        = $clog2(DEPTH),
  localparam int          CW        = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  fetch_entry_t  din,
  input  logic          pop,
  input  logic          flush,
  output fetch_entry_t  dout,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= RST_ENTRY;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/rv32_ifetch.sv
// priRV32 instruction fetch stage with credit-based prefetch.
// Option: PRIRV32_IFETCH_MISALIGN_EN traps misaligned redirects.
module rv32_ifetch
  import prirv32_pkg::*;
#(
  parameter xlen_t RESET_PC   = PRIRV32_RESET_PC,
  parameter int    FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  rv32_ifetch_if.master       imem,
  input  logic                redirect_valid,
  input  xlen_t               redirect_pc,
  output logic                inst_valid,
  input  logic                inst_ready,
  output inst_t               inst_data,
`ifdef PRIRV32_IFETCH_MISALIGN_EN
  output xlen_t               inst_pc,
  output logic                inst_misalign
`else
  output xlen_t               inst_pc
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam fetch_entry_t RST_ENTRY = '{pc: RESET_PC, data: '0};

  fetch_state_e  state_q;
  fetch_state_e  state_d;
  xlen_t         fetch_pc;
  xlen_t         rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] inflight_d;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit_used;
  logic          started;
  logic          req_hs;
  logic          rsp_ok;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fault_pend;
  logic          misal;
  xlen_t         target;
  fetch_entry_t  head;

`ifdef PRIRV32_IFETCH_MISALIGN_EN
  assign target = redirect_pc;
  assign misal  = redirect_pc[1:0] != 2'b00;
`else
  assign target = redirect_pc & 32'hFFFF_FFFC;
  assign misal  = 1'b0;
`endif

  assign req_hs      = imem.imem_req_valid && imem.imem_req_ready;
  assign rsp_ok      = imem.imem_rsp_valid && (outstanding != '0);
  assign inflight_d  = outstanding + CW'(req_hs) - CW'(rsp_ok);
  assign credit_used = (CW+1)'(fifo_count) + (CW+1)'(outstanding);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid) state_d = misal ? fetch_state_e'(1) : FETCH;
  end

  always_comb begin
    imem.imem_req_valid = started && (state_q == FETCH) &&
                          (credit_used < (CW+1)'(FIFO_DEPTH));
    imem.imem_req_addr  = fetch_pc;
  end

  // Everything in flight at a redirect, same-cycle traffic included, is stale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started     <= 1'b0;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      fault_pend  <= 1'b0;
    end else begin
      started     <= 1'b1;
      outstanding <= inflight_d;
      if (redirect_valid) begin
        fetch_pc   <= target;
        rsp_pc     <= target;
        discard    <= inflight_d;
        fault_pend <= misal;
      end else begin
        if (req_hs) fetch_pc <= fetch_pc + 32'd4;
        if (rsp_ok) begin
          if (discard != '0) discard <= discard - CW'(1);
          else               rsp_pc  <= rsp_pc + 32'd4;
        end
        if (fault_pend && inst_ready) fault_pend <= 1'b0;
      end
    end
  end

  assign fifo_push = rsp_ok && (discard == '0) && !redirect_valid;
  assign fifo_pop  = inst_valid && inst_ready && !redirect_valid;

  rv32_ifetch_fifo #(
    .DEPTH     (FIFO_DEPTH),
    .RST_ENTRY (RST_ENTRY)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   ('{pc: rsp_pc, data: imem.imem_rsp_data}),
    .pop   (fifo_pop),
    .flush (redirect_valid),
    .dout  (head),
    .count (fifo_count)
  );

  always_comb begin
    inst_valid = fifo_count != '0;
    inst_pc    = head.pc;
    inst_data  = head.data;
`ifdef PRIRV32_IFETCH_MISALIGN_EN
    inst_misalign = 1'b0;
`endif
    if (fault_pend) begin
      inst_valid = 1'b1;
      inst_pc    = rsp_pc;
      inst_data  = '0;
`ifdef PRIRV32_IFETCH_MISALIGN_EN
      inst_misalign = 1'b1;
`endif
    end
  end

  a_rsp_credit: assert property (
    @(posedge clk) disable iff (!rst_n)
    imem.imem_rsp_valid |-> (outstanding != '0)
  );

endmodule

// File: tb/tb_rv32_ifetch.sv
// Randomized bench for rv32_ifetch against a stream/credit model.
// Build with PRIRV32_IFETCH_MISALIGN_EN to cover the fault path.
module tb_rv32_ifetch;
  import prirv32_pkg::*;

  localparam int    DEPTH = 2;
  localparam xlen_t RPC   = 32'h0000_0000;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  redirect_valid;
  xlen_t redirect_pc;
  logic  inst_valid;
  logic  inst_ready;
  inst_t inst_data;
  xlen_t inst_pc;
`ifdef PRIRV32_IFETCH_MISALIGN_EN
  logic  inst_misalign;
`endif

  always #5 clk = ~clk;

  rv32_ifetch_if bus ();

  rv32_ifetch #(
    .RESET_PC   (RPC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem           (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
`ifdef PRIRV32_IFETCH_MISALIGN_EN
    .inst_pc        (inst_pc),
    .inst_misalign  (inst_misalign)
`else
    .inst_pc        (inst_pc)
`endif
  );

  typedef struct {
    xlen_t addr;
    int    due;
    int    epoch;
  } mreq_t;

  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  mreq_t mq[$];
  int    epoch, buffered, last_due;
  xlen_t exp_pc, exp_req, fault_pc;
  bit    started_m, fault_mode, fault_pend;
  int    lat_min = 1, lat_max = 1, rdy_pct = 100, dec_pct = 100;
  bit    redir_now, redir_busy_arm, busy_hit;
  xlen_t redir_tgt;
  bit    o_hs, o_pop, o_redir;
  xlen_t o_addr, o_pop_pc;
  inst_t o_pop_data;
  int    o_cyc;

  function automatic inst_t mem_word(xlen_t a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.imem_req_ready = 1'b0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    mq.delete();
    epoch = 0; buffered = 0;
    exp_pc = RPC; exp_req = RPC;
    started_m = 0; fault_mode = 0; fault_pend = 0;
    redir_now = 0; redir_busy_arm = 0; busy_hit = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_due = cyc;
  endtask

  // One clock: drive at negedge, check model, account the coming edge.
  task automatic cycle();
    bit    rsp, redir, hs, pop, exp_rv, exp_iv;
    xlen_t tgt, e_pc;
    inst_t e_data;
    mreq_t e;
    int    lat, due;
`ifdef PRIRV32_IFETCH_MISALIGN_EN
    logic  e_mis;
`endif
    rsp = (mq.size() > 0) && (mq[0].due <= cyc);
    bus.imem_rsp_valid = rsp;
    bus.imem_rsp_data  = rsp ? mem_word(mq[0].addr) : $urandom;
    bus.imem_req_ready = ($urandom_range(99) < rdy_pct);
    inst_ready = ($urandom_range(99) < dec_pct);
    redir = redir_now || (redir_busy_arm && rsp &&
            bus.imem_req_valid && bus.imem_req_ready);
    redirect_valid = redir;
    redirect_pc = redir_tgt;
    #1;
    exp_rv = started_m && !fault_mode && (mq.size() + buffered < DEPTH);
    checks++;
    if (bus.imem_req_valid !== exp_rv) begin
      errors++;
      $display("FAIL req_valid cyc=%0d: got %b want %b",
               cyc, bus.imem_req_valid, exp_rv);
    end
    if (exp_rv) begin
      checks++;
      if (bus.imem_req_addr !== exp_req) begin
        errors++;
        $display("FAIL req_addr cyc=%0d: got %h want %h",
                 cyc, bus.imem_req_addr, exp_req);
      end
    end
    exp_iv = (buffered > 0) || fault_pend;
    checks++;
    if (inst_valid !== exp_iv) begin
      errors++;
      $display("FAIL inst_valid cyc=%0d: got %b want %b",
               cyc, inst_valid, exp_iv);
    end
    if (exp_iv) begin
      e_pc = fault_pend ? fault_pc : exp_pc;
      e_data = fault_pend ? 32'h0 : mem_word(exp_pc);
      checks++;
      if (inst_pc !== e_pc || inst_data !== e_data) begin
        errors++;
        $display("FAIL inst cyc=%0d: got pc=%h data=%h want pc=%h data=%h",
                 cyc, inst_pc, inst_data, e_pc, e_data);
      end
`ifdef PRIRV32_IFETCH_MISALIGN_EN
      e_mis = fault_pend;
      checks++;
      if (inst_misalign !== e_mis) begin
        errors++;
        $display("FAIL misalign cyc=%0d: got %b want %b",
                 cyc, inst_misalign, e_mis);
      end
`endif
    end
    hs  = bus.imem_req_valid && bus.imem_req_ready;
    pop = inst_valid && inst_ready && !redir;
    o_hs = hs; o_addr = bus.imem_req_addr; o_pop = pop;
    o_pop_pc = inst_pc; o_pop_data = inst_data;
    o_redir = redir; o_cyc = cyc;
    if (rsp) begin
      e = mq.pop_front();
      if (e.epoch == epoch && !redir) buffered++;
    end
    if (pop) begin
      if (fault_pend) fault_pend = 0;
      else if (buffered > 0) begin
        buffered--;
        exp_pc += 32'd4;
      end
    end
    if (hs) begin
      lat = $urandom_range(lat_max, lat_min);
      due = cyc + lat;
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq.push_back('{addr: bus.imem_req_addr, due: due, epoch: epoch});
      exp_req += 32'd4;
    end
    if (redir) begin
      epoch++;
      buffered = 0;
`ifdef PRIRV32_IFETCH_MISALIGN_EN
      tgt = redir_tgt;
      fault_mode = tgt[1:0] != 2'b00;
      fault_pend = fault_mode;
      fault_pc = tgt;
`else
      tgt = {redir_tgt[31:2], 2'b00};
`endif
      exp_pc = tgt; exp_req = tgt;
      if (redir_busy_arm && !redir_now) busy_hit = 1;
      redir_now = 0; redir_busy_arm = 0;
    end
    if (rst_n) started_m = 1;
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks += 5;
    if (bus.imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL rst_req_valid: got %b want 0", bus.imem_req_valid);
    end
    if (bus.imem_req_addr !== RPC) begin
      errors++; $display("FAIL rst_req_addr: got %h want %h", bus.imem_req_addr, RPC);
    end
    if (inst_valid !== 1'b0) begin
      errors++; $display("FAIL rst_inst_valid: got %b want 0", inst_valid);
    end
    if (inst_data !== 32'h0) begin
      errors++; $display("FAIL rst_inst_data: got %h want 0", inst_data);
    end
    if (inst_pc !== RPC) begin
      errors++; $display("FAIL rst_inst_pc: got %h want %h", inst_pc, RPC);
    end
    do_reset();
    checks++;
    if (bus.imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL pre_start_req: got %b want 0", bus.imem_req_valid);
    end
    lat_min = 1; lat_max = 1; rdy_pct = 100; dec_pct = 100;
    cycle();
    checks++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RPC) begin
      errors++;
      $display("FAIL first_req: got v=%b a=%h want v=1 a=%h",
               bus.imem_req_valid, bus.imem_req_addr, RPC);
    end
  endtask

  task automatic test_stream();
    int c0, c1, pops;
    xlen_t first_pc;
    do_reset();
    lat_min = 1; lat_max = 1; rdy_pct = 100; dec_pct = 100;
    c0 = -1; c1 = -1; pops = 0; first_pc = '1;
    for (int i = 0; i < 20; i++) begin
      if (bus.imem_req_valid && c0 < 0) c0 = cyc;
      if (inst_valid && c1 < 0) begin
        c1 = cyc; first_pc = inst_pc;
      end
      cycle();
      if (o_pop) pops++;
    end
    checks++;
    if (c0 < 0 || c1 - c0 != 2) begin
      errors++; $display("FAIL stream_latency: got %0d want 2", c1 - c0);
    end
    checks++;
    if (first_pc !== RPC) begin
      errors++; $display("FAIL stream_first_pc: got %h want %h", first_pc, RPC);
    end
    checks++;
    if (pops < 12) begin
      errors++; $display("FAIL stream_rate: got %0d pops want >=12", pops);
    end
  endtask

  task automatic test_stall();
    int n, p, r;
    do_reset();
    lat_min = 1; lat_max = 1; rdy_pct = 100; dec_pct = 0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (o_hs) n++;
    end
    checks++;
    if (n != DEPTH) begin
      errors++; $display("FAIL stall_reqs: got %0d want %0d", n, DEPTH);
    end
    checks++;
    if (bus.imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL stall_valid: got %b want 0", bus.imem_req_valid);
    end
    dec_pct = 100; p = -1; r = -1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (o_pop && p < 0) p = o_cyc;
      if (o_hs && p >= 0 && r < 0) r = o_cyc;
    end
    checks++;
    if (p < 0 || r != p + 1) begin
      errors++; $display("FAIL stall_resume: got req at %0d want %0d", r, p + 1);
    end
  endtask

  task automatic test_redirect_inflight();
    bit seen, got;
    do_reset();
    lat_min = 3; lat_max = 3; rdy_pct = 100; dec_pct = 100;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (mq.size() == 2) begin
        seen = 1; break;
      end
      cycle();
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL redir_inflight_setup: got %0d in flight want 2", mq.size());
    end
    redir_now = 1; redir_tgt = 32'h100;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      cycle();
      if (o_pop) begin
        got = 1;
        checks++;
        if (o_pop_pc !== 32'h100 || o_pop_data !== mem_word(32'h100)) begin
          errors++;
          $display("FAIL redir_first: got pc=%h d=%h want pc=100 d=%h",
                   o_pop_pc, o_pop_data, mem_word(32'h100));
        end
      end
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL redir_timeout: got no pop want one");
    end
  endtask

  task automatic test_same_cycle();
    bit got;
    do_reset();
    lat_min = 1; lat_max = 1; rdy_pct = 100; dec_pct = 100;
    redir_busy_arm = 1; redir_tgt = 32'h340;
    for (int i = 0; i < 20 && !busy_hit; i++) cycle();
    checks++;
    if (!busy_hit) begin
      errors++; $display("FAIL same_cycle_setup: got no overlap want one");
    end
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle();
      if (o_pop) begin
        got = 1;
        checks++;
        if (o_pop_pc !== 32'h340) begin
          errors++; $display("FAIL same_cycle_pc: got %h want 340", o_pop_pc);
        end
      end
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL same_cycle_timeout: got no pop want one");
    end
  endtask

  task automatic test_wrap();
    bit saw_top, wrapped;
    do_reset();
    lat_min = 1; lat_max = 1; rdy_pct = 100; dec_pct = 100;
    cycle();
    redir_now = 1; redir_tgt = 32'hFFFF_FFF8;
    saw_top = 0; wrapped = 0;
    for (int i = 0; i < 14; i++) begin
      cycle();
      if (o_hs && !o_redir) begin
        if (saw_top && o_addr == 32'h0) wrapped = 1;
        saw_top = (o_addr == 32'hFFFF_FFFC);
      end
    end
    checks++;
    if (!wrapped) begin
      errors++; $display("FAIL wrap: got no 0xFFFFFFFC->0x0 step want one");
    end
  endtask

  task automatic test_misalign();
    bit got;
    int n;
    xlen_t want;
    do_reset();
    lat_min = 1; lat_max = 2; rdy_pct = 100; dec_pct = 100;
    repeat (6) cycle();
    redir_now = 1; redir_tgt = 32'h102;
`ifdef PRIRV32_IFETCH_MISALIGN_EN
    cycle();
    checks++;
    if (inst_valid !== 1'b1 || inst_misalign !== 1'b1 ||
        inst_pc !== 32'h102 || inst_data !== 32'h0) begin
      errors++;
      $display("FAIL fault_entry: got v=%b m=%b pc=%h d=%h want 1 1 102 0",
               inst_valid, inst_misalign, inst_pc, inst_data);
    end
    n = 0;
    repeat (6) begin
      cycle();
      if (o_hs) n++;
    end
    checks++;
    if (n != 0 || inst_valid !== 1'b0) begin
      errors++; $display("FAIL fault_stall: got reqs=%0d v=%b want 0 0", n, inst_valid);
    end
    redir_now = 1; redir_tgt = 32'h200;
    want = 32'h200;
`else
    want = 32'h100;
`endif
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle();
      if (o_pop) begin
        got = 1;
        checks++;
        if (o_pop_pc !== want) begin
          errors++; $display("FAIL align_resume: got %h want %h", o_pop_pc, want);
        end
      end
    end
    checks++;
    if (!got) begin
      errors++; $display("FAIL align_timeout: got no pop want one");
    end
  endtask

  task automatic test_random();
    int pops;
    do_reset();
    lat_min = 1; lat_max = 4; rdy_pct = 70; dec_pct = 60;
    pops = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) < 4) begin
        redir_now = 1;
        redir_tgt = $urandom;
        if ($urandom_range(3) != 0) redir_tgt[1:0] = 2'b00;
      end
      cycle();
      if (o_pop) pops++;
    end
    checks++;
    if (pops < 50) begin
      errors++; $display("FAIL random_progress: got %0d pops want >=50", pops);
    end
  endtask

  task automatic test_reset_mid();
    lat_min = 1; lat_max = 1; rdy_pct = 100; dec_pct = 0;
    repeat (5) cycle();
    #2 rst_n = 1'b0;
    #1;
    checks += 5;
    if (bus.imem_req_valid !== 1'b0) begin
      errors++; $display("FAIL mid_rst_valid: got %b want 0", bus.imem_req_valid);
    end
    if (bus.imem_req_addr !== RPC) begin
      errors++; $display("FAIL mid_rst_addr: got %h want %h", bus.imem_req_addr, RPC);
    end
    if (inst_valid !== 1'b0) begin
      errors++; $display("FAIL mid_rst_iv: got %b want 0", inst_valid);
    end
    if (inst_data !== 32'h0) begin
      errors++; $display("FAIL mid_rst_data: got %h want 0", inst_data);
    end
    if (inst_pc !== RPC) begin
      errors++; $display("FAIL mid_rst_pc: got %h want %h", inst_pc, RPC);
    end
    do_reset();
    dec_pct = 100;
    repeat (10) cycle();
  endtask

  initial begin
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.imem_req_ready = 1'b0;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    redir_tgt = '0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_inflight();
    test_same_cycle();
    test_wrap();
    test_misalign();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
